// File: rtl/frame_stream_source.sv
// -----------------------------------------------------------------------------
// frame_stream_source
//
// Raster read engine sitting between the camera frame buffer and the VGA
// scaler sink. It walks the frame buffer in raster order, absorbs the RAM read
// latency with a small skid FIFO, picks one of NCH filter channels per frame
// and presents the pixels as a ready/valid stream with SOP/EOP markers.
// Channel changes only take effect at a frame start, so a frame is never torn.
//
// Optional feature: define TEST_PATTERN_EN to add an internal 8-bar colour
// pattern selected by chan_sel == NCH (chan_sel/active_ch widen by one code).
//
// Ports
//   clk         in   pixel clock
//   reset_n     in   synchronous active-low reset
//   resync      in   flush everything and restart at pixel 0
//   chan_sel    in   requested channel, taken when pixel 0 is issued
//   rd_addr     out  frame-buffer read address
//   ch_data     in   per-channel pixel, RAM_LAT cycles after rd_addr; ch0 = LSBs
//   m_data      out  output pixel
//   m_valid     out  output pixel valid
//   m_ready     in   downstream ready
//   m_sop       out  first pixel of frame (qualified by m_valid)
//   m_eop       out  last pixel of frame (qualified by m_valid)
//   active_ch   out  channel latched for the most recently started frame
//   frame_done  out  one-cycle pulse after the EOP beat is accepted
// -----------------------------------------------------------------------------
module frame_stream_source #(
  parameter int H_PIXELS = 320,
  parameter int V_LINES  = 240,
  parameter int PIX_W    = 30,
  parameter int NCH      = 4,
  parameter int ADDR_W   = 17,
  parameter int RAM_LAT  = 1,
`ifdef TEST_PATTERN_EN
  localparam int CH_W    = $clog2(NCH + 1)
`else
  localparam int CH_W    = (NCH > 1) ? $clog2(NCH) : 1
`endif
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   resync,
  input  logic [CH_W-1:0]        chan_sel,
  output logic [ADDR_W-1:0]      rd_addr,
  input  logic [NCH*PIX_W-1:0]   ch_data,
  output logic [PIX_W-1:0]       m_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic                   m_sop,
  output logic                   m_eop,
  output logic [CH_W-1:0]        active_ch,
  output logic                   frame_done
);

  localparam int DEPTH = RAM_LAT + 1;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int SUM_W = $clog2(2 * DEPTH + 1);
  localparam int COL_W = (H_PIXELS > 1) ? $clog2(H_PIXELS) : 1;
  localparam int ROW_W = (V_LINES > 1) ? $clog2(V_LINES) : 1;

  // Tag travelling alongside each outstanding read. The channel rides with
  // the tag so pixels of the old frame still in flight keep their channel.
  typedef struct packed {
    logic            vld;
    logic            sop;
    logic            eop;
    logic [CH_W-1:0] ch;
`ifdef TEST_PATTERN_EN
    logic [2:0]      bar;
`endif
  } tag_t;

  typedef struct packed {
    logic             sop;
    logic             eop;
    logic [PIX_W-1:0] data;
  } beat_t;

  logic [COL_W-1:0]  r_col;
  logic [ROW_W-1:0]  r_row;
  logic [ADDR_W-1:0] r_addr;
  logic [CH_W-1:0]   r_active_ch;
  tag_t              r_tag [RAM_LAT];
  beat_t             r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_eop_xfer;

  logic              w_last_col;
  logic              w_sop_pix;
  logic              w_eop_pix;
  logic              w_sel_ok;
  logic [CH_W-1:0]   w_frame_ch;
  logic [SUM_W-1:0]  w_inflight;
  logic [SUM_W-1:0]  w_used;
  logic              w_issue;
  logic              w_pop;
  logic              w_push;
  tag_t              w_tag_in;
  tag_t              w_ret;
  beat_t             w_head;
  logic [PIX_W-1:0]  w_cap;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_last_col = (r_col == COL_W'(H_PIXELS - 1));
  assign w_sop_pix  = (r_col == '0) && (r_row == '0);
  assign w_eop_pix  = w_last_col && (r_row == ROW_W'(V_LINES - 1));

`ifdef TEST_PATTERN_EN
  assign w_sel_ok = (32'(chan_sel) <= 32'(NCH));
`else
  assign w_sel_ok = (32'(chan_sel) < 32'(NCH));
`endif
  assign w_frame_ch = (w_sop_pix && w_sel_ok) ? chan_sel : r_active_ch;

  assign w_head  = r_mem[r_rd_ptr];
  assign w_ret   = r_tag[RAM_LAT-1];
  assign m_valid = (r_count != '0);
  assign w_pop   = m_valid & m_ready;
  assign w_push  = w_ret.vld;

  // Credit check: entries already in the FIFO plus reads still in the RAM
  // pipe, minus the beat leaving this cycle, must leave room for one more.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // through the block can leave it unassigned and infer a latch.
    w_inflight = '0;
    for (int i = 0; i < RAM_LAT; i++) begin
      w_inflight = w_inflight + SUM_W'(r_tag[i].vld);
    end
  end

  assign w_used  = SUM_W'(r_count) + w_inflight - SUM_W'(w_pop);
  assign w_issue = ~resync & (w_used < SUM_W'(DEPTH));

  always_comb begin
    w_tag_in     = '0;
    w_tag_in.vld = w_issue;
    w_tag_in.sop = w_sop_pix;
    w_tag_in.eop = w_eop_pix;
    w_tag_in.ch  = w_frame_ch;
`ifdef TEST_PATTERN_EN
    w_tag_in.bar = 3'((32'(r_col) * 32'd8) / 32'(H_PIXELS));
`endif
  end

  // Returning pixel selected by the channel the read was issued under.
  always_comb begin
    w_cap = '0;
    for (int c = 0; c < NCH; c++) begin
      if (w_ret.ch == CH_W'(c)) w_cap = ch_data[c*PIX_W +: PIX_W];
    end
`ifdef TEST_PATTERN_EN
    // Bars run white, yellow, cyan, green, magenta, red, blue, black:
    // red is on for bars with bit1 clear, green bit2 clear, blue bit0 clear.
    if (w_ret.ch == CH_W'(NCH)) begin
      w_cap = PIX_W'({{(PIX_W/3){~w_ret.bar[1]}},
                      {(PIX_W/3){~w_ret.bar[2]}},
                      {(PIX_W/3){~w_ret.bar[0]}}});
    end
`endif
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!reset_n) begin
      r_col       <= '0;
      r_row       <= '0;
      r_addr      <= '0;
      r_active_ch <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_eop_xfer  <= 1'b0;
      for (int i = 0; i < RAM_LAT; i++) r_tag[i] <= '0;
      // NOTE: the skid buffer is a handful of flops, not a RAM, so it is
      // reset to keep m_data/m_sop/m_eop at zero out of reset.
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      // A beat coinciding with resync is dropped, so it cannot end a frame.
      r_eop_xfer <= w_pop & w_head.eop & ~resync;
      if (resync) begin
        r_col    <= '0;
        r_row    <= '0;
        r_addr   <= '0;
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
        for (int i = 0; i < RAM_LAT; i++) r_tag[i] <= '0;
      end else begin
        if (w_issue) begin
          if (w_eop_pix) begin
            r_col  <= '0;
            r_row  <= '0;
            r_addr <= '0;
          end else begin
            r_addr <= r_addr + ADDR_W'(1);
            if (w_last_col) begin
              r_col <= '0;
              r_row <= r_row + ROW_W'(1);
            end else begin
              r_col <= r_col + COL_W'(1);
            end
          end
          if (w_sop_pix) r_active_ch <= w_frame_ch;
        end
        r_tag[0] <= w_tag_in;
        for (int i = 1; i < RAM_LAT; i++) r_tag[i] <= r_tag[i-1];
        if (w_push) begin
          r_mem[r_wr_ptr] <= '{sop: w_ret.sop, eop: w_ret.eop, data: w_cap};
          r_wr_ptr        <= ptr_inc(r_wr_ptr);
        end
        if (w_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
        r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      end
    end
  end

  assign rd_addr    = r_addr;
  assign m_data     = w_head.data;
  assign m_sop      = w_head.sop;
  assign m_eop      = w_head.eop;
  assign active_ch  = r_active_ch;
  assign frame_done = r_eop_xfer & ~resync;

endmodule
